// File: rtl/alu9_pkg.sv
// ALU_9 shared opcodes, shift-amount width and shifter mode type.
package alu9_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } sh_mode_t;

  function automatic sh_mode_t op_to_mode(
    input logic [3:0] op
  );
    sh_mode_t m;
    case (op)
      OP_SRL:  m = SH_SRL;
      OP_SRA:  m = SH_SRA;
      default: m = SH_SLL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu9_shifter.sv
// ALU_9 combinational barrel shifter (SLL/SRL/SRA).
module alu9_shifter
  import alu9_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  input  sh_mode_t           mode,
  output logic [WIDTH-1:0]   result
);

  always_comb begin
    result = '0;
    case (mode)
      SH_SLL:  result = A << shamt;
      SH_SRL:  result = A >> shamt;
      SH_SRA:  result = $unsigned($signed(A) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_9.sv
// ALU_9: registered 9-op ALU, 1-cycle latency.
// Optional signed-overflow flag Ovf when ALU9_OVF_EN is defined.
module alu_9
  import alu9_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] C,
  output logic             Zero
`ifdef ALU9_OVF_EN
  ,
  output logic             Ovf
`endif
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sh_res;
  logic [WIDTH-1:0] c_nxt;
  sh_mode_t         sh_mode;

  assign sum     = A + B;
  assign diff    = A - B;
  assign sh_mode = op_to_mode(Op);

  alu9_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .A      (A),
    .shamt  (B[SHAMT_W-1:0]),
    .mode   (sh_mode),
    .result (sh_res)
  );

  always_comb begin
    c_nxt = '0;
    case (Op)
      OP_ADD:  c_nxt = sum;
      OP_SUB:  c_nxt = diff;
      OP_AND:  c_nxt = A & B;
      OP_OR:   c_nxt = A | B;
      OP_XOR:  c_nxt = A ^ B;
      OP_NOR:  c_nxt = ~(A | B);
      OP_SLL,
      OP_SRL,
      OP_SRA:  c_nxt = sh_res;
      default: c_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C    <= '0;
      Zero <= 1'b1;
    end else begin
      C    <= c_nxt;
      Zero <= (c_nxt == '0);
    end
  end

`ifdef ALU9_OVF_EN
  logic ovf_nxt;
  logic a_s;
  logic b_s;

  assign a_s = A[WIDTH-1];
  assign b_s = B[WIDTH-1];

  // Overflow: operands' effective signs agree but result sign differs.
  always_comb begin
    ovf_nxt = 1'b0;
    case (Op)
      OP_ADD:  ovf_nxt = (a_s == b_s) && (sum[WIDTH-1] != a_s);
      OP_SUB:  ovf_nxt = (a_s != b_s) && (diff[WIDTH-1] != a_s);
      default: ovf_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Ovf <= 1'b0;
    else       Ovf <= ovf_nxt;
  end
`endif

endmodule

// File: tb/tb_alu_9.sv
// ALU_9 bench: directed steps with an expected-result queue.
// Ovf checks compiled in only when ALU9_OVF_EN is defined.
module tb_alu_9;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic [31:0] C;
  logic        Zero;
`ifdef ALU9_OVF_EN
  logic        Ovf;
`endif

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] c;
    logic        z;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_9 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .C     (C),
    .Zero  (Zero)
`ifdef ALU9_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_c(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    logic signed [32:0] s;
    if (op == 4'd0) s = $signed({a[31], a}) + $signed({b[31], b});
    else if (op == 4'd1) s = $signed({a[31], a}) - $signed({b[31], b});
    else return 1'b0;
    return s[32] != s[31];
  endfunction

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    tests++;
    assert (C === e.c) else begin
      failed++;
      $error("FAIL %s C got %h want %h", e.tag, C, e.c);
    end
    tests++;
    assert (Zero === e.z) else begin
      failed++;
      $error("FAIL %s Zero got %b want %b", e.tag, Zero, e.z);
    end
`ifdef ALU9_OVF_EN
    tests++;
    assert (Ovf === e.ovf) else begin
      failed++;
      $error("FAIL %s Ovf got %b want %b", e.tag, Ovf, e.ovf);
    end
`endif
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic step(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op,
    input logic [31:0] ec,
    input logic        eo,
    input string       tag
  );
    exp_t e;
    A  = a;
    B  = b;
    Op = op;
    e.c   = ec;
    e.z   = (ec == 32'd0);
    e.ovf = eo;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_head();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    tests++;
    assert (C === 32'd0) else begin
      failed++;
      $error("FAIL %s C got %h want 00000000", tag, C);
    end
    tests++;
    assert (Zero === 1'b1) else begin
      failed++;
      $error("FAIL %s Zero got %b want 1", tag, Zero);
    end
`ifdef ALU9_OVF_EN
    tests++;
    assert (Ovf === 1'b0) else begin
      failed++;
      $error("FAIL %s Ovf got %b want 0", tag, Ovf);
    end
`endif
  endtask

  logic [31:0] sweep_c [10];
  logic [31:0] ra;
  logic [31:0] rb;
  logic [3:0]  rop;

  initial begin
    sweep_c = '{32'd6, 32'd4, 32'd1, 32'd5, 32'd4,
                32'hFFFF_FFFA, 32'd10, 32'd2, 32'd2, 32'd0};
    reset = 1'b1;
    A  = 32'h1234_5678;
    B  = 32'h1;
    Op = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_init");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      step(32'd5, 32'd1, 4'(i), sweep_c[i], 1'b0, $sformatf("sweep_op%0d", i));

    step(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b0, "add_wrap");
    step(32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, "sub_wrap");
    step(32'h8000_0000, 32'd4, 4'd8, 32'hF800_0000, 1'b0, "sra_sign");
    step(32'h8000_0000, 32'd4, 4'd7, 32'h0800_0000, 1'b0, "srl_zero");
    step(32'd1, 32'h24, 4'd6, 32'h10, 1'b0, "sll_hi_ign");
    step(32'hA5A5_0F0F, 32'hFFFF_FFE0, 4'd6, 32'hA5A5_0F0F, 1'b0, "sll_sh0");
    step(32'hA5A5_0F0F, 32'h0, 4'd8, 32'hA5A5_0F0F, 1'b0, "sra_sh0");
    step(32'h8000_0001, 32'd31, 4'd8, 32'hFFFF_FFFF, 1'b0, "sra_31");
    step(32'h8000_0001, 32'd31, 4'd7, 32'h1, 1'b0, "srl_31");
    step(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd15, 32'd0, 1'b0, "op15");
    step(32'h7FFF_FFFF, 32'd1, 4'd0, 32'h8000_0000, 1'b1, "add_ovf");
    step(32'h7FFF_FFFF, 32'd1, 4'd2, 32'd1, 1'b0, "and_noovf");
    step(32'h8000_0000, 32'd1, 4'd1, 32'h7FFF_FFFF, 1'b1, "sub_ovf");

    // Mid-cycle input wiggle must not reach C before the edge.
    A = 32'd9; B = 32'd3; Op = 4'd0;
    #2;
    A = 32'd5; B = 32'd1; Op = 4'd2;
    sb.push_back('{c: 32'd1, z: 1'b0, ovf: 1'b0, tag: "glitch"});
    @(posedge clk);
    #1;
    check_head();
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'($urandom_range(0, 9));
      step(ra, rb, rop, model_c(ra, rb, rop), model_ovf(ra, rb, rop),
           $sformatf("rand%0d_op%0d", i, rop));
    end

    // Async reset between edges while C=6, with a pending input set.
    step(32'd5, 32'd1, 4'd0, 32'd6, 1'b0, "pre_reset");
    A = 32'd7; B = 32'd1; Op = 4'd0;
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("reset_async");
    @(posedge clk);
    #1;
    check_reset_state("reset_held");
    @(negedge clk);
    reset = 1'b0;
    A = 32'd5; B = 32'd1; Op = 4'd1;
    step(32'd5, 32'd1, 4'd1, 32'd4, 1'b0, "post_reset");

    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL sb_leftover: %0d entries remain, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_9.md
ALU_9 -- requirements
Module: alu_9

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the datapath width of A, B and C.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 A  input  WIDTH  first operand.
REQ-006 B  input  WIDTH  second operand; B[4:0] is the shift amount for shift ops.
REQ-007 Op  input  4  operation select.
REQ-008 C  output  WIDTH  registered result.
REQ-009 Zero  output  1  registered flag; 1 when the registered C equals 0.

Function
REQ-010 The module SHALL sample A, B and Op at every rising clk edge and drive the result on C one cycle later, with 1-cycle latency and no handshake.
REQ-011 The module SHALL implement these Op encodings:
- 0 ADD: A+B, carry discarded, wraps modulo 2^WIDTH.
- 1 SUB: A-B, wraps modulo 2^WIDTH.
- 2 AND: A&B.
- 3 OR: A|B.
- 4 XOR: A^B.
- 5 NOR: ~(A|B).
- 6 SLL: A<<B[4:0].
- 7 SRL: logical A>>B[4:0], zero fill.
- 8 SRA: arithmetic A>>>B[4:0], sign fill from A[WIDTH-1].
REQ-012 Op values 9 through 15 SHALL produce C=0 and Zero=1.
REQ-013 A shift amount of 0 SHALL pass A unchanged; upper bits of B above B[4:0] SHALL be ignored for shift ops.
REQ-014 Zero SHALL be computed from the same next-state value as C and registered in the same cycle.
REQ-015 Input changes between clock edges SHALL NOT affect C until the next rising edge.

Reset
REQ-016 While reset=1, C SHALL be 0 and Zero SHALL be 1, asynchronously and independent of clk.
REQ-017 On the first rising edge after reset deasserts, C SHALL load the result of the inputs present at that edge.
REQ-018 Reset asserted mid-operation SHALL discard the pending result.

Configuration
REQ-019 When ALU9_OVF_EN is defined, the module SHALL add output Ovf (1 bit, registered), set on signed two's-complement overflow for ADD and SUB and 0 for all other ops; Ovf SHALL reset to 0.
REQ-020 When ALU9_OVF_EN is not defined, the Ovf port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-021 A shared package alu9_pkg SHALL hold the opcode constants (OP_ADD=0 through OP_SRA=8) and the shift-amount width constant (5).
REQ-022 The shift operations SHALL be implemented in one combinational sub-module, alu9_shifter, with inputs A, shamt and mode (SLL/SRL/SRA) and output result; the add/sub, logic and output registers SHALL live in alu_9.

Verification
REQ-023 Sweep with A=5, B=1, Op=0..9 across consecutive cycles -> C = 6, 4, 1, 5, 4, 0xFFFFFFFA, 10, 2, 2, 0; Zero=1 only for Op=9.
REQ-024 Wrap-around: A=0xFFFFFFFF, B=1, Op=0 -> C=0, Zero=1; A=0, B=1, Op=1 -> C=0xFFFFFFFF.
REQ-025 Arithmetic vs logical shift: A=0x80000000, B=4 -> Op=8 gives C=0xF8000000, Op=7 gives C=0x08000000; B=0x24 with Op=6 and A=1 gives C=0x10.
REQ-026 Reset: assert reset between clock edges while C=6 -> C=0 and Zero=1 immediately; after deassertion, the next edge loads the current result.
REQ-027 With ALU9_OVF_EN defined: A=0x7FFFFFFF, B=1, Op=0 -> C=0x80000000, Ovf=1; the same operands with Op=2 -> Ovf=0.
